pipelined_gen_alu: RTL and testbench
====================================

// Module: pipelined_gen_alu
// PURPOSE
//  Parametrised, pipelined successor to the generate-built adder/logic arrays.
//  Splits a WIDTH-bit carry chain into STAGES registered slices with a generate loop.
//  Performs a runtime-selected add/sub/bitwise op per transaction.
//  Uses valid/ready handshakes on both sides; sits between operand sources and result sinks.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be a multiple of STAGES
//  STAGES  2  pipeline slices; each slice handles S = WIDTH/STAGES bits (STAGES >= 1)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand transaction valid
//  in_ready   out  1      block can accept a transaction this cycle
//  op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 NAND, 111 NOR
//  a, b       in   WIDTH  operands (unsigned/two's complement)
//  out_valid  out  1      result valid
//  out_ready  in   1      sink accepts result this cycle
//  result     out  WIDTH  operation result
//  cout       out  1      carry out (ADD); no-borrow (SUB); 0 for bitwise ops
//  ovf        out  1      signed overflow (ADD/SUB); 0 for bitwise ops
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valids=0; out_valid=0, result=0, cout=0, ovf=0.
//    in_ready=1 one cycle after reset release. Reset mid-operation discards all in-flight data.
//  - Registers: stage registers R1..R_STAGES. Slice k computes bits [k*S +: S] from R(k-1), with R0 = inputs.
//    Each R holds: valid, op, remaining a/b upper bits, finished result bits, and chain carry.
//    R_STAGES drives the outputs directly; no combinational path from inputs to outputs.
//  - SUB = a + ~b + 1: the carry into slice 0 is 1 for SUB, 0 otherwise.
//  - Bitwise ops are evaluated per slice. Their carry is forced to 0.
//  - ovf = carry into MSB XOR carry out of MSB, for ADD/SUB only. It is evaluated in the last slice.
//  - Handshake: a transfer occurs on an edge where valid & ready are both 1.
//    Stage k advances when R_k is empty or stage k+1 advances; the last stage advances on out_ready.
//    in_ready = !R1.valid | (stage 1 advances). There is no combinational path from in_valid to in_ready.
//  - Latency: STAGES rising edges, counting the accepting edge.
//    Throughput is 1 op/cycle while out_ready=1. Capacity is STAGES transactions.
//  - While out_valid=1 & out_ready=0, result/cout/ovf are held stable.
//  - Ordering is strictly FIFO. No transaction is dropped or duplicated under any stall pattern.
//  - Simultaneous accept and emit in the same cycle is legal when full; the pipeline stays full.
//  - op values are all defined; no illegal encodings.
// CONFIGURATION
//  - Macro ALU_SAT_EN, defined: ADD/SUB saturate on signed overflow.
//    Positive overflow gives result = 0111..1; negative overflow gives result = 1000..0.
//    ovf still reports 1 and cout is unchanged.
//  - Macro ALU_SAT_EN, undefined: two's-complement wrap-around; ovf flags it only.
// TESTING  (WIDTH=8, STAGES=2 unless noted)
//  1. ADD a=0xA6 b=0x69, out_ready=1:
//     result=0x0F, cout=1, ovf=0. out_valid rises exactly 2 edges after accept.
//  2. SUB a=0x05 b=0x06:
//     result=0xFF, cout=0, ovf=0. SUB 0x06-0x05 gives 0x01, cout=1.
//  3. ADD 0x7F+0x01: result=0x80, ovf=1, cout=0 (0x7F with ALU_SAT_EN).
//     SUB 0x80-0x01: result=0x7F, ovf=1 (0x80 with ALU_SAT_EN).
//  4. Backpressure: out_ready=0, drive 4 back-to-back ops.
//     2 accepted, then in_ready=0 and outputs stay stable.
//     Raise out_ready: all 4 results emerge in order, 1 per cycle, none lost or duplicated.
//  5. Bitwise: XOR 0xFF^0xFF -> 0x00; NAND 0xF0,0x3C -> 0xCF; NOR 0x0F,0x30 -> 0xC0.
//     cout=ovf=0 in every case. Also check AND, OR, XNOR.
//  6. Reset mid-operation: 2 ops in flight, pulse rst_n low between edges.
//     out_valid=0 immediately; no stale result after release.
//     Repeat tests 1-3 with STAGES=1, 4, 8 and WIDTH=16.

Source files
------------

// File: rtl/pipelined_gen_alu.sv
// pipelined_gen_alu: WIDTH-bit add/sub/bitwise ALU. The carry chain is split into
// STAGES registered slices, with valid/ready handshakes on the input and output sides.
// Optional feature macro: ALU_SAT_EN. When it is defined, ADD/SUB saturate on signed
// overflow. When it is undefined, results wrap around in two's complement.
module pipelined_gen_alu #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned S = WIDTH / STAGES;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_NOR  = 3'b111;

    // Stage registers; index k holds the output of slice k.
    logic             r_valid [STAGES];
    logic [2:0]       r_op    [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_res   [STAGES];
    logic             r_carry [STAGES];
    logic             r_ovf   [STAGES];

    // Next-state values produced by each slice.
    logic             nxt_valid [STAGES];
    logic [2:0]       nxt_op    [STAGES];
    logic [WIDTH-1:0] nxt_a     [STAGES];
    logic [WIDTH-1:0] nxt_b     [STAGES];
    logic [WIDTH-1:0] nxt_res   [STAGES];
    logic             nxt_carry [STAGES];
    logic             nxt_ovf   [STAGES];

    logic [STAGES-1:0] adv;
    logic              rdy_q;

    // Backward advance chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !r_valid[STAGES-1] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = !r_valid[k] || adv[k+1];
        end
    end

    // rdy_q holds in_ready low until one edge after reset is released.
    assign in_ready = rdy_q && adv[0];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
        logic             i_valid;
        logic [2:0]       i_op;
        logic [WIDTH-1:0] i_a;
        logic [WIDTH-1:0] i_b;
        logic [WIDTH-1:0] i_res;
        logic             i_carry;

        if (k == 0) begin : g_head
            assign i_valid = in_valid && in_ready;
            assign i_op    = op;
            assign i_a     = a;
            assign i_b     = b;
            assign i_res   = '0;
            assign i_carry = (op == OP_SUB);
        end else begin : g_body
            assign i_valid = r_valid[k-1];
            assign i_op    = r_op[k-1];
            assign i_a     = r_a[k-1];
            assign i_b     = r_b[k-1];
            assign i_res   = r_res[k-1];
            assign i_carry = r_carry[k-1];
        end

        logic [S-1:0]     s_a;
        logic [S-1:0]     s_braw;
        logic [S-1:0]     s_b;
        logic [S:0]       s_sum;
        logic [S-1:0]     s_bits;
        logic             arith;
        logic             c_msb;
        logic             v_c;
        logic [WIDTH-1:0] res_c;

        // Slice datapath: S-bit add (b inverted for SUB) or per-slice bitwise op.
        always_comb begin
            arith  = (i_op[2:1] == 2'b00);
            s_a    = i_a[k*S +: S];
            s_braw = i_b[k*S +: S];
            s_b    = (i_op == OP_SUB) ? ~s_braw : s_braw;
            s_sum  = {1'b0, s_a} + {1'b0, s_b} + (S+1)'(i_carry);
            s_bits = '0;
            case (i_op)
                OP_ADD, OP_SUB: s_bits = s_sum[S-1:0];
                OP_AND:         s_bits = s_a & s_braw;
                OP_OR:          s_bits = s_a | s_braw;
                OP_XOR:         s_bits = s_a ^ s_braw;
                OP_XNOR:        s_bits = ~(s_a ^ s_braw);
                OP_NAND:        s_bits = ~(s_a & s_braw);
                OP_NOR:         s_bits = ~(s_a | s_braw);
                default:        s_bits = '0;
            endcase
            res_c = i_res;
            res_c[k*S +: S] = s_bits;
            // Carry into the slice MSB, recovered from the sum bit and the operand bits.
            c_msb = s_a[S-1] ^ s_b[S-1] ^ s_sum[S-1];
            v_c   = arith && (c_msb ^ s_sum[S]);
`ifdef ALU_SAT_EN
            // The operand signs agree on overflow, so a's sign gives the direction.
            if ((k == int'(STAGES) - 1) && v_c) begin
                res_c = s_a[S-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end

        assign nxt_valid[k] = i_valid;
        assign nxt_op[k]    = i_op;
        assign nxt_a[k]     = i_a;
        assign nxt_b[k]     = i_b;
        assign nxt_res[k]   = res_c;
        assign nxt_carry[k] = arith && s_sum[S];
        assign nxt_ovf[k]   = v_c;
    end

    // Stage registers. A stage loads data only when it advances with a valid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                r_valid[k] <= 1'b0;
                r_op[k]    <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_res[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_ovf[k]   <= 1'b0;
            end
        end else begin
            rdy_q <= 1'b1;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (adv[k]) begin
                    r_valid[k] <= nxt_valid[k];
                    if (nxt_valid[k]) begin
                        r_op[k]    <= nxt_op[k];
                        r_a[k]     <= nxt_a[k];
                        r_b[k]     <= nxt_b[k];
                        r_res[k]   <= nxt_res[k];
                        r_carry[k] <= nxt_carry[k];
                        r_ovf[k]   <= nxt_ovf[k];
                    end
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign result    = r_res[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf[STAGES-1];

endmodule

// File: tb/tb_pipelined_gen_alu.sv
// Scoreboard testbench for pipelined_gen_alu. The driver pushes expected results
// from a signed-arithmetic reference model. The monitor pops and compares them on
// each output handshake.
module tb_pipelined_gen_alu;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    pipelined_gen_alu #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   sink_mode  = 1;   // 0 stall, 1 always ready, 2 random

    // Reference model: signed/unsigned integer arithmetic on the full operands.
    function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
        longint sx, sy, sum, hi, lo;
        exp_t   e;
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        sx = x[WIDTH-1] ? longint'(x) - (longint'(1) << WIDTH) : longint'(x);
        sy = y[WIDTH-1] ? longint'(y) - (longint'(1) << WIDTH) : longint'(y);
        e   = '0;
        sum = 0;
        if (o == 3'd0 || o == 3'd1) begin
            if (o == 3'd0) begin
                sum = sx + sy;
                e.c = (longint'(x) + longint'(y)) >= (longint'(1) << WIDTH);
            end else begin
                sum = sx - sy;
                e.c = (x >= y);
            end
            e.v   = (sum > hi) || (sum < lo);
            e.res = WIDTH'(sum);
`ifdef ALU_SAT_EN
            if (e.v) e.res = (sum > hi) ? WIDTH'(hi) : WIDTH'(lo);
`endif
        end else begin
            case (o)
                3'd2:    e.res = x & y;
                3'd3:    e.res = x | y;
                3'd4:    e.res = x ^ y;
                3'd5:    e.res = ~(x ^ y);
                3'd6:    e.res = ~(x & y);
                default: e.res = ~(x | y);
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Step to the next falling edge and drive out_ready according to sink_mode.
    task automatic step();
        @(negedge clk);
        case (sink_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            in_valid = 1'b0;
        end
    endtask

    // Present one transaction until it is accepted. The model result is queued on acceptance.
    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done) begin
            step();
            in_valid = 1'b1;
            op = o;
            a  = x;
            b  = y;
            #1;
            if (in_ready) begin
                q.push_back(model(o, x, y));
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    compared++;
                    mismatched++;
                    $display("FAIL send_timeout: in_ready stuck 0 for op %0d", o);
                    done = 1;
                end
            end
        end
    endtask

    // Monitor: compare on each output transfer and check that stalled outputs hold.
    initial begin
        exp_t             e;
        bit               stall_prev;
        logic [WIDTH+1:0] held;
        stall_prev = 0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (stall_prev && out_valid)
                    chk("hold_stable", 32'({result, cout, ovf}), 32'(held));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", result);
                    end else begin
                        e = q.pop_front();
                        chk("result", 32'({result, cout, ovf}), 32'({e.res, e.c, e.v}));
                    end
                end
                stall_prev = out_valid && !out_ready;
                held = {result, cout, ovf};
            end else begin
                stall_prev = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic directed_basic();
        send(3'd0, 8'hA6, 8'h69);
        send(3'd1, 8'h05, 8'h06);
        send(3'd1, 8'h06, 8'h05);
        send(3'd0, 8'h7F, 8'h01);
        send(3'd1, 8'h80, 8'h01);
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;

        // Values while reset is asserted.
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Latency: out_valid rises exactly STAGES edges after the accepting edge.
        sink_mode = 1;
        send(3'd0, 8'hA6, 8'h69);
        for (int i = 1; i <= int'(STAGES); i++) begin
            idle(1);
            #1;
            chk("latency_out_valid", 32'(out_valid), (i == int'(STAGES)) ? 32'd1 : 32'd0);
        end
        idle(2);

        directed_basic();
        // Bitwise ops.
        send(3'd4, 8'hFF, 8'hFF);
        send(3'd6, 8'hF0, 8'h3C);
        send(3'd7, 8'h0F, 8'h30);
        send(3'd2, 8'hCA, 8'h5F);
        send(3'd3, 8'h81, 8'h18);
        send(3'd5, 8'hA5, 8'h0F);
        idle(4);

        // Backpressure: fill the pipeline, then check that the input stalls.
        sink_mode = 0;
        for (int i = 0; i < int'(STAGES); i++) send(3'(i), 8'(8'h11 * (i + 1)), 8'(8'h23 + i));
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1'b1; op = 3'd4; a = 8'h3C; b = 8'hC3;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        sink_mode = 1;
        send(3'd4, 8'h3C, 8'hC3);
        send(3'd1, 8'h10, 8'h20);
        idle(STAGES + 3);

        // Reset in the middle of an operation.
        sink_mode = 0;
        send(3'd0, 8'h12, 8'h34);
        send(3'd1, 8'h56, 8'h78);
        idle(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        q.delete();
        #1;
        rst_n = 1'b1;
        sink_mode = 1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            #1;
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        directed_basic();
        idle(STAGES + 2);

        // Randomized traffic with random sink stalls and input gaps.
        sink_mode = 2;
        repeat (300) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 7))
                0: ra = {1'b0, {(WIDTH-1){1'b1}}};
                1: rb = {1'b1, {(WIDTH-1){1'b0}}};
                2: ra = '1;
                default: ;
            endcase
            send(3'($urandom_range(0, 7)), ra, rb);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Drain everything still in flight.
        sink_mode = 1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
